// File: rtl/catraca_pkg.sv
// Shared types and credit arithmetic for the multi-card turnstile.
package catraca_pkg;

  typedef enum logic [0:0] {TRAVADA, LIBERADA} estado_t;

  // Debit is only ever applied to a non-zero balance, so the sum never underflows.
  function automatic int unsigned sat_add(input int unsigned credit, input int unsigned load,
                                          input logic debit, input logic refund,
                                          input int unsigned max);
    int unsigned sum;
    sum = credit + load + {31'd0, refund} - {31'd0, debit};
    return (sum > max) ? max : sum;
  endfunction

endpackage

// File: rtl/catraca_multi_if.sv
// Card requests/loads, rotation sensor and display/status outputs of the turnstile.
interface catraca_multi_if #(
  parameter int NCARDS = 2,
  parameter int CW     = 3,
  parameter int PASS_W = 8
);
  localparam int IW = (NCARDS > 1) ? $clog2(NCARDS) : 1;

  logic [NCARDS-1:0]    passe;
  logic [NCARDS*CW-1:0] carrega;
  logic                 giro;
  logic                 catraca;
  logic [IW-1:0]        cartao_ativo;
  logic [CW-1:0]        saldo;
  logic                 negado;
  logic                 conflito;
  logic [PASS_W-1:0]    passagens;

  modport master (output passe, carrega, giro,
                  input  catraca, cartao_ativo, saldo, negado, conflito, passagens);
  modport slave  (input  passe, carrega, giro,
                  output catraca, cartao_ativo, saldo, negado, conflito, passagens);
endinterface

// File: rtl/catraca_saldo.sv
// Saturating credit register for one card: load, debit on grant, refund on timeout.
module catraca_saldo import catraca_pkg::*; #(
  parameter int MAX_CREDIT = 5,
  parameter int CW         = 3
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic [CW-1:0] carrega,
  input  logic          debito,
  input  logic          estorno,
  output logic [CW-1:0] saldo
);

  always_ff @(posedge clk_2) begin
    if (reset) saldo <= '0;
    else       saldo <= CW'(sat_add(32'(saldo), 32'(carrega), debito, estorno, MAX_CREDIT));
  end

endmodule

// File: rtl/catraca_multi.sv
// Turnstile controller for NCARDS prepaid cards: arbitration, open timer, refund and
// passage counting; per-card balances live in catraca_saldo instances.
module catraca_multi import catraca_pkg::*; #(
  parameter int NCARDS      = 2,
  parameter int MAX_CREDIT  = 5,
  parameter int CW          = $clog2(MAX_CREDIT+1),
  parameter int OPEN_CYCLES = 4,
  parameter int PASS_W      = 8
) (
  input  logic          clk_2,
  input  logic          reset,
  catraca_multi_if.slave bus
);
  localparam int IW = (NCARDS > 1) ? $clog2(NCARDS) : 1;
  localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  estado_t                  estado, estado_n;
  logic [TW-1:0]            timer;
  logic [IW-1:0]            ativo, menor;
  logic [NCARDS-1:0][CW-1:0] credito;
  logic [NCARDS-1:0]        debito, estorno;
  logic                     unico, varios, fim, concede, negado, conflito;
  logic [PASS_W-1:0]        passagens;

  always_comb begin
    menor = '0;
    for (int i = NCARDS-1; i >= 0; i--) if (bus.passe[i]) menor = IW'(i);
  end

  assign unico  = $onehot(bus.passe);
  assign varios = (bus.passe != '0) && !unico;
  assign fim    = (timer == TW'(OPEN_CYCLES-1));

  always_ff @(posedge clk_2) begin
    if (reset) estado <= TRAVADA;
    else       estado <= estado_n;
  end

  // Grant looks at the registered balance only; same-cycle loads land after the decision.
  always_comb begin
    estado_n = estado;
    concede  = 1'b0;
    debito   = '0;
    estorno  = '0;
    case (estado)
      TRAVADA: if (unico && credito[menor] != '0) begin
        concede  = 1'b1;
        debito   = bus.passe;
        estado_n = LIBERADA;
      end
      LIBERADA: if (bus.giro) estado_n = TRAVADA;
      else if (fim) begin
        estado_n       = TRAVADA;
        estorno[ativo] = 1'b1;
      end
      default: estado_n = TRAVADA;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      timer     <= '0;
      ativo     <= '0;
      negado    <= 1'b0;
      conflito  <= 1'b0;
      passagens <= '0;
    end else begin
      negado   <= (estado == TRAVADA) && unico && (credito[menor] == '0);
      conflito <= (estado == TRAVADA) && varios;
      if (concede) begin
        ativo <= menor;
        timer <= '0;
      end else if (estado == LIBERADA && !bus.giro && !fim) begin
        timer <= timer + 1'b1;
      end
      if (estado == LIBERADA && bus.giro) passagens <= passagens + 1'b1;
    end
  end

  for (genvar i = 0; i < NCARDS; i++) begin : g_card
    catraca_saldo #(.MAX_CREDIT(MAX_CREDIT), .CW(CW)) u_saldo (
      .clk_2  (clk_2),
      .reset  (reset),
      .carrega(bus.carrega[i*CW +: CW]),
      .debito (debito[i]),
      .estorno(estorno[i]),
      .saldo  (credito[i])
    );
  end

  assign bus.catraca      = (estado == LIBERADA);
  assign bus.cartao_ativo = ativo;
  assign bus.saldo        = (bus.passe != '0) ? credito[menor] : credito[ativo];
  assign bus.negado       = negado;
  assign bus.conflito     = conflito;
  assign bus.passagens    = passagens;

endmodule
